// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared encodings for the data-memory stage.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
//
// Contents: memory op codes (MEM_NONE/LOAD/STORE/HALT), FSM state encodings
// (ST_IDLE/ST_WAIT/ST_DONE), timeout counter width, access decode helper.
package mem_stage_pkg;

  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_LOAD  = 2'd1;
  localparam logic [1:0] MEM_STORE = 2'd2;
  localparam logic [1:0] MEM_HALT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int CTR_W = 8;

  // True for ops that actually touch data memory.
  function automatic logic is_access(input logic [1:0] op);
    return (op != MEM_NONE) && (op != MEM_HALT);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: 8-bit clear/enable counter with terminal-count flag.
// Latency: count updates one cycle after i_clr/i_en; o_tc is combinational.
// Backpressure: none; the owner decides when to clear and enable.
//
// Ports:
//   clk, rst      core clock, async active-high reset
//   i_clr         synchronous clear (wins over i_en)
//   i_en          increment enable
//   o_tc          high while the count equals TC
module mem_timeout_ctr
  import mem_stage_pkg::*;
#(
  parameter logic [CTR_W-1:0] TC = 8'd63
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [CTR_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == TC);

endmodule

// File: rtl/mem_stage.sv
// mem_stage: data-memory stage; issues loads/stores and registers load data for writeback.
// Latency: hit completes in the issue cycle (mem_out next cycle); misses wait for dm_done or TIMEOUT.
// Backpressure: dm_stall re-presents the request; stall freezes upstream until completion.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN (odd-address requests are rejected with err).
//
// Ports:
//   clk, rst                      core clock, async active-high reset
//   valid, mem_op, addr, wr_data  instruction from execute
//   dm_en, dm_wr, dm_addr, dm_wdata   request to data memory
//   dm_stall, dm_done, dm_rdata, dm_err  response from data memory
//   mem_out                       registered load result to writeback
//   stall                         freeze upstream stages and PC
//   halted                        sticky halt indication
//   err                           one-cycle error pulse (fault, timeout, misalignment)
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int AW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid,
  input  logic [1:0]    mem_op,
  input  logic [AW-1:0] addr,
  input  logic [AW-1:0] wr_data,
  output logic          dm_en,
  output logic          dm_wr,
  output logic [AW-1:0] dm_addr,
  output logic [AW-1:0] dm_wdata,
  input  logic          dm_stall,
  input  logic          dm_done,
  input  logic [AW-1:0] dm_rdata,
  input  logic          dm_err,
  output logic [AW-1:0] mem_out,
  output logic          stall,
  output logic          halted,
  output logic          err
);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [AW-1:0] r_mem_out;
  logic [AW-1:0] r_lat_addr;
  logic [AW-1:0] r_lat_wdata;
  logic          r_lat_wr;
  logic          r_halted;
  logic          r_err;

  logic w_req;
  logic w_misalign;
  logic w_issue;
  logic w_hit;
  logic w_err_set;
  logic w_capture;
  logic w_latch;
  logic w_ctr_clr;
  logic w_ctr_en;
  logic w_ctr_tc;
  logic w_set_halt;

  assign w_req = valid & is_access(mem_op) & ~r_halted;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_req & addr[0];
`else
  assign w_misalign = 1'b0;
`endif

  // A misaligned request never reaches memory; everything else is issued.
  assign w_issue = w_req & ~w_misalign;
  assign w_hit   = ~dm_stall & dm_done;

  mem_timeout_ctr #(
    .TC(CTR_W'(TIMEOUT - 1))
  ) u_timeout_ctr (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_ctr_clr),
    .i_en  (w_ctr_en),
    .o_tc  (w_ctr_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    dm_en       = 1'b0;
    dm_wr       = r_lat_wr;
    dm_addr     = r_lat_addr;
    dm_wdata    = r_lat_wdata;
    stall       = 1'b0;
    w_err_set   = 1'b0;
    w_capture   = 1'b0;
    w_latch     = 1'b0;
    w_ctr_clr   = 1'b0;
    w_ctr_en    = 1'b0;
    w_set_halt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Request goes straight out from execute; no register in the path.
        dm_en    = w_issue;
        dm_wr    = (mem_op == MEM_STORE);
        dm_addr  = addr;
        dm_wdata = wr_data;
        stall    = w_issue & ~w_hit;
        if (w_misalign) begin
          w_err_set = 1'b1;
        end else if (w_issue) begin
          if (dm_err) begin
            // Fault beats a same-cycle hit: report it and drop the data.
            w_err_set = 1'b1;
          end else if (dm_stall) begin
            w_state_nxt = ST_IDLE;
          end else if (dm_done) begin
            w_capture   = (mem_op == MEM_LOAD);
            w_state_nxt = ST_DONE;
          end else begin
            w_latch     = 1'b1;
            w_ctr_clr   = 1'b1;
            w_state_nxt = ST_WAIT;
          end
        end
        if (valid && (mem_op == MEM_HALT)) begin
          w_set_halt = 1'b1;
        end
      end

      ST_WAIT: begin
        stall    = 1'b1;
        w_ctr_en = 1'b1;
        if (dm_err) begin
          w_err_set   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (dm_done) begin
          w_capture   = ~r_lat_wr;
          w_state_nxt = ST_DONE;
        end else if (w_ctr_tc) begin
          // Hung transaction: abandon it, leave mem_out alone.
          w_err_set   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end

      ST_DONE: begin
        // One unstalled cycle lets the pipeline advance past this op.
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mem_out   <= '0;
      r_lat_addr  <= '0;
      r_lat_wdata <= '0;
      r_lat_wr    <= 1'b0;
      r_halted    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_set;
      if (w_capture) begin
        r_mem_out <= dm_rdata;
      end
      if (w_set_halt) begin
        r_halted <= 1'b1;
      end
      if (w_latch) begin
        r_lat_wr    <= (mem_op == MEM_STORE);
        r_lat_addr  <= addr;
        r_lat_wdata <= wr_data;
      end
    end
  end

  assign mem_out = r_mem_out;
  assign halted  = r_halted;
  assign err     = r_err;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Data-memory stage of the 16-bit processor; sits between execute and writeback and produces the load result writeback selects for memory-sourced writes.
- Drives a multi-cycle data memory (cache/bank system) with stall/done handshake.
- Holds the core via `stall` until each load/store completes.
- Detects memory errors and hung transactions.

Parameters:
- TIMEOUT, 64, max cycles in WAIT before abort with err; legal range 1..255.
- AW, 16, address/data width.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- valid  in  1  instruction present this cycle
- mem_op  in  2  MEM_NONE / MEM_LOAD / MEM_STORE / MEM_HALT (from ops.vh)
- addr  in  AW  effective address (execute ALU result)
- wr_data  in  AW  store data
- dm_en  out  1  memory request strobe
- dm_wr  out  1  1=write, 0=read
- dm_addr  out  AW  request address
- dm_wdata  out  AW  request write data
- dm_stall  in  1  memory busy; request this cycle not accepted
- dm_done  in  1  transaction complete; dm_rdata valid
- dm_rdata  in  AW  read data
- dm_err  in  1  memory fault
- mem_out  out  AW  registered load result, to writeback
- stall  out  1  freeze upstream stages and PC
- halted  out  1  sticky halt indication
- err  out  1  one-cycle error pulse

Behaviour:
- Reset (async): state=IDLE, mem_out=0, halted=0, err=0, timeout counter=0; dm_en=0.
- req = valid & (mem_op==MEM_LOAD | mem_op==MEM_STORE) & !halted.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - dm_en=req; dm_wr=(mem_op==MEM_STORE); dm_addr=addr; dm_wdata=wr_data, all combinational.
  - req & dm_stall: stay IDLE, re-present request next cycle.
  - req & !dm_stall & dm_done (hit): capture dm_rdata into mem_out if load; go DONE.
  - req & !dm_stall & !dm_done: latch op/addr/data; go WAIT; counter=0.
  - valid & MEM_HALT: halted<=1, sticky until reset; no request issued.
- WAIT:
  - dm_en=0; dm_addr/dm_wdata/dm_wr driven from latched copies.
  - Counter increments each cycle.
  - dm_done: capture dm_rdata if latched op is load; go DONE.
  - Counter reaches TIMEOUT-1 without dm_done: err pulse, go IDLE, mem_out unchanged.
- DONE: stall=0 for exactly one cycle so the pipeline advances; go IDLE unconditionally. A new req is only evaluated in IDLE, i.e. one cycle later.
- stall = (IDLE & req & !(!dm_stall & dm_done)) | WAIT.
- dm_err sampled in any state with dm_en or WAIT: err pulse next cycle, go IDLE, capture suppressed.
- dm_err and dm_done in the same cycle: dm_err wins.
- Stores never modify mem_out. mem_out holds its value until the next completed load.
- Reset asserted mid-WAIT: immediate return to IDLE; outstanding transaction abandoned.
- Counter width = 8 bits; no wrap possible within legal TIMEOUT.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: req with addr[0]==1 suppresses dm_en, pulses err next cycle, leaves stall low, leaves state in IDLE.
- Undefined: no check; the address passes to memory unmodified.

Decomposition:
- ops.vh (shared include) gains:
  - MEM_NONE=2'd0, MEM_LOAD=2'd1, MEM_STORE=2'd2, MEM_HALT=2'd3
  - state encodings ST_IDLE/ST_WAIT/ST_DONE
- Sub-module `mem_timeout_ctr`: 8-bit clear/enable counter with terminal-count output. Instantiated once.
- The FSM stays in mem_stage.

Test Plan:
- Load hit: LOAD addr=0x0040, dm_stall=0, dm_done=1, dm_rdata=0xBEEF -> dm_en 1 cycle, stall=0, mem_out=0xBEEF next cycle.
- Store miss: STORE addr=0x0100, wr_data=0x1234, dm_done after 3 cycles -> stall high for 3 cycles, dm_addr/dm_wdata held at 0x0100/0x1234 throughout, DONE 1 cycle, mem_out unchanged.
- Busy retry: dm_stall=1 for 2 cycles on LOAD 0x0002 -> dm_en high all 3 cycles, stall high, WAIT entered on 3rd cycle.
- Timeout: TIMEOUT=4, LOAD accepted, dm_done never -> err pulse after 4 WAIT cycles, state IDLE, stall low.
- Reset mid-WAIT: rst pulsed during WAIT -> state IDLE, mem_out=0, stall=0, halted=0 immediately.
- Alignment (with MEM_ALIGN_CHECK_EN): LOAD addr=0x0003 -> dm_en=0, err pulse next cycle; without the macro, dm_en=1 and dm_addr=0x0003.
